// File: rtl/csr_exc_unit_if.sv
// csr_exc_unit_if: bundle between the WB stage and the CSR/exception unit.
// Carries the csrrd/csrwr/csrxchg access port, the exception/ertn commit
// signals, and the redirect/interrupt results returned to the front end.
interface csr_exc_unit_if;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [31:0] ex_entry;
  logic [31:0] era_out;
  logic        has_int;

  modport master (
    output csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex, ertn_flush, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
    input  csr_rvalue, ex_entry, era_out, has_int
  );

  modport slave (
    input  csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex, ertn_flush, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
    output csr_rvalue, ex_entry, era_out, has_int
  );
endinterface

// File: rtl/csr_exc_unit.sv
// csr_exc_unit: LA32 exception-related CSRs, architectural timer and the
// CSR read/write port. Exception commit beats ertn, which beats a CSR write;
// the losing event of a cycle is simply dropped.
module csr_exc_unit #(
  parameter int unsigned TIMER_W = 32,
  parameter logic [31:0] TID_RST = 32'h0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] hw_int_in,
  input  logic       ipi_int_in,
  csr_exc_unit_if.slave bus
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;

  // CRMD keeps PLV[1:0], IE[2], DA[3], PG[4]; PRMD keeps PPLV[1:0], PIE[2].
  logic [4:0]         crmd;
  logic [2:0]         prmd;
  logic [12:0]        ecfg_lie;
  logic [1:0]         is_sw;
  logic [7:0]         is_hw;
  logic               is_ti;
  logic               is_ipi;
  logic [5:0]         ecode;
  logic [8:0]         esubcode;
  logic [31:0]        era;
  logic [31:0]        badv;
  logic [25:0]        eentry;
  logic [31:0]        tid;
  logic [TIMER_W-1:0] tcfg;
  logic [TIMER_W-1:0] tval;

  logic [12:0]        is_vec;
  logic [31:0]        rdata;
  logic [31:0]        merged;
  logic               csr_wr;
  logic               wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv;
  logic               wr_eentry, wr_tid, wr_tcfg, wr_ticlr;
  logic               ticlr_hit;
  logic               timer_fire;
  logic [TIMER_W-1:0] tcfg_new;
  logic [TIMER_W-1:0] reload;

  assign is_vec = {is_ipi, is_ti, 1'b0, is_hw, is_sw};

  // Combinational read mux; unmapped addresses and TICLR read as zero.
  always_comb begin
    rdata = '0;
    case (bus.csr_num)
      CSR_CRMD:   rdata = {27'b0, crmd};
      CSR_PRMD:   rdata = {29'b0, prmd};
      CSR_ECFG:   rdata = {19'b0, ecfg_lie};
      CSR_ESTAT:  rdata = {1'b0, esubcode, ecode, 3'b0, is_vec};
      CSR_ERA:    rdata = era;
      CSR_BADV:   rdata = badv;
      CSR_EENTRY: rdata = {eentry, 6'b0};
      CSR_TID:    rdata = tid;
      CSR_TCFG:   rdata = 32'(tcfg);
      CSR_TVAL:   rdata = 32'(tval);
      default:    rdata = '0;
    endcase
  end

  // Write decode: the masked merge is taken against the current read value,
  // so each register just picks its writable bits out of 'merged'.
  always_comb begin
    csr_wr     = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
    merged     = (rdata & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
    wr_crmd    = csr_wr & (bus.csr_num == CSR_CRMD);
    wr_prmd    = csr_wr & (bus.csr_num == CSR_PRMD);
    wr_ecfg    = csr_wr & (bus.csr_num == CSR_ECFG);
    wr_estat   = csr_wr & (bus.csr_num == CSR_ESTAT);
    wr_era     = csr_wr & (bus.csr_num == CSR_ERA);
    wr_badv    = csr_wr & (bus.csr_num == CSR_BADV);
    wr_eentry  = csr_wr & (bus.csr_num == CSR_EENTRY);
    wr_tid     = csr_wr & (bus.csr_num == CSR_TID);
    wr_tcfg    = csr_wr & (bus.csr_num == CSR_TCFG);
    wr_ticlr   = csr_wr & (bus.csr_num == CSR_TICLR);
    ticlr_hit  = wr_ticlr & bus.csr_wvalue[0] & bus.csr_wmask[0];
    tcfg_new   = merged[TIMER_W-1:0];
    reload     = {tcfg[TIMER_W-1:2], 2'b00};
    timer_fire = ~wr_tcfg & tcfg[0] & (tval == TIMER_W'(1));
  end

  // CRMD: exception drops to PLV0 with interrupts off, ertn restores from PRMD.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd <= 5'h08;
    end else if (bus.wb_ex) begin
      crmd[2:0] <= 3'b000;
    end else if (bus.ertn_flush) begin
      crmd[2:0] <= prmd;
    end else if (wr_crmd) begin
      crmd <= merged[4:0];
    end
  end

  // PRMD: saves PLV/IE on exception entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prmd <= 3'b000;
    end else if (bus.wb_ex) begin
      prmd <= crmd[2:0];
    end else if (wr_prmd) begin
      prmd <= merged[2:0];
    end
  end

  // ECFG: local interrupt enables, bit 10 is reserved and stays zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ecfg_lie <= '0;
    end else if (wr_ecfg) begin
      ecfg_lie <= merged[12:0] & 13'h1BFF;
    end
  end

  // ESTAT: sampled interrupt lines, software IS bits, timer IS and exception codes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_sw    <= '0;
      is_hw    <= '0;
      is_ti    <= 1'b0;
      is_ipi   <= 1'b0;
      ecode    <= '0;
      esubcode <= '0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (wr_estat) begin
        is_sw <= merged[1:0];
      end
      if (bus.wb_ex) begin
        ecode    <= bus.wb_ecode;
        esubcode <= bus.wb_esubcode;
      end
      if (timer_fire) begin
        is_ti <= 1'b1;
      end else if (ticlr_hit) begin
        is_ti <= 1'b0;
      end
    end
  end

  // ERA: return address captured at exception commit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      era <= '0;
    end else if (bus.wb_ex) begin
      era <= bus.wb_pc;
    end else if (wr_era) begin
      era <= merged;
    end
  end

  // BADV: only address errors record a faulting address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badv <= '0;
    end else if (bus.wb_ex) begin
      if (bus.wb_ecode == ECODE_ADE) begin
        badv <= bus.wb_pc;
      end else if (bus.wb_ecode == ECODE_ALE) begin
        badv <= bus.wb_vaddr;
      end
    end else if (wr_badv) begin
      badv <= merged;
    end
  end

  // EENTRY and TID: plain software-written registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      eentry <= '0;
      tid    <= TID_RST;
    end else begin
      if (wr_eentry) begin
        eentry <= merged[31:6];
      end
      if (wr_tid) begin
        tid <= merged;
      end
    end
  end

  // Timer: a TCFG write reloads (or freezes when disabled), otherwise count down
  // and on reaching 1 either reload (periodic) or park at zero (one-shot).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg <= '0;
      tval <= '0;
    end else if (wr_tcfg) begin
      tcfg <= tcfg_new;
      if (tcfg_new[0]) begin
        tval <= {tcfg_new[TIMER_W-1:2], 2'b00};
      end
    end else if (tcfg[0] && (tval != '0)) begin
      if (tval == TIMER_W'(1)) begin
        tval <= tcfg[1] ? reload : '0;
      end else begin
        tval <= tval - TIMER_W'(1);
      end
    end
  end

  assign bus.csr_rvalue = rdata;
  assign bus.ex_entry   = {eentry, 6'b0};
  assign bus.era_out    = era;
  assign bus.has_int    = crmd[2] & (|(is_vec & ecfg_lie));

endmodule

// File: tb/tb_csr_exc_unit.sv
// tb_csr_exc_unit: directed stimulus for csr_exc_unit, checked every cycle
// against an architectural model of the CSR file plus hand-computed literals.
module tb_csr_exc_unit;

  logic       clk;
  logic       resetn;
  logic [7:0] hw_int_in;
  logic       ipi_int_in;

  csr_exc_unit_if bus();

  csr_exc_unit #(
    .TIMER_W(32),
    .TID_RST(32'h0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit model_valid = 1'b0;

  // Architectural model: each CSR held as its full 32-bit visible value.
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv;
  logic [31:0] m_eentry, m_tid, m_tcfg, m_tval;

  // Bits software may change, straight from the CSR map.
  function automatic logic [31:0] writable_mask(input logic [13:0] num);
    case (num)
      14'h000: return 32'h0000_001F;
      14'h001: return 32'h0000_0007;
      14'h004: return 32'h0000_1BFF;
      14'h005: return 32'h0000_0003;
      14'h006: return 32'hFFFF_FFFF;
      14'h007: return 32'hFFFF_FFFF;
      14'h00C: return 32'hFFFF_FFC0;
      14'h040: return 32'hFFFF_FFFF;
      14'h041: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] num);
    case (num)
      14'h000: return m_crmd;
      14'h001: return m_prmd;
      14'h004: return m_ecfg;
      14'h005: return m_estat;
      14'h006: return m_era;
      14'h007: return m_badv;
      14'h00C: return m_eentry;
      14'h040: return m_tid;
      14'h041: return m_tcfg;
      14'h042: return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [13:0] num);
    logic [31:0] m;
    m = bus.csr_wmask & writable_mask(num);
    return (old & ~m) | (bus.csr_wvalue & m);
  endfunction

  function automatic logic model_has_int();
    return m_crmd[2] && ((m_estat[12:0] & m_ecfg[12:0]) != 13'h0);
  endfunction

  // Model step: one commit per cycle, then interrupt sampling, then the timer.
  always @(posedge clk or negedge resetn) begin : model_step
    logic [31:0] n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_badv;
    logic [31:0] n_eentry, n_tid, n_tcfg, n_tval;
    logic        wr, tcfg_wr, ticlr;
    if (!resetn) begin
      m_crmd <= 32'h8;  m_prmd <= 0;  m_ecfg <= 0;   m_estat <= 0; m_era <= 0;
      m_badv <= 0;      m_eentry <= 0; m_tid <= 32'h0; m_tcfg <= 0; m_tval <= 0;
      model_valid <= 1'b1;
    end else begin
      n_crmd = m_crmd; n_prmd = m_prmd; n_ecfg = m_ecfg; n_estat = m_estat;
      n_era = m_era; n_badv = m_badv; n_eentry = m_eentry; n_tid = m_tid;
      n_tcfg = m_tcfg; n_tval = m_tval;
      wr      = bus.csr_we && !bus.wb_ex && !bus.ertn_flush;
      tcfg_wr = wr && (bus.csr_num == 14'h041);
      ticlr   = 1'b0;
      if (bus.wb_ex) begin
        n_prmd  = m_crmd % 8;
        n_crmd  = m_crmd - (m_crmd % 8);
        n_estat = (m_estat & 32'h0000_FFFF) | (32'(bus.wb_esubcode) << 22) | (32'(bus.wb_ecode) << 16);
        n_era   = bus.wb_pc;
        if (bus.wb_ecode == 6'd8) n_badv = bus.wb_pc;
        if (bus.wb_ecode == 6'd9) n_badv = bus.wb_vaddr;
      end else if (bus.ertn_flush) begin
        n_crmd = m_crmd - (m_crmd % 8) + (m_prmd % 8);
      end else if (wr) begin
        case (bus.csr_num)
          14'h000: n_crmd   = apply_write(m_crmd, bus.csr_num);
          14'h001: n_prmd   = apply_write(m_prmd, bus.csr_num);
          14'h004: n_ecfg   = apply_write(m_ecfg, bus.csr_num);
          14'h005: n_estat  = apply_write(m_estat, bus.csr_num);
          14'h006: n_era    = apply_write(m_era, bus.csr_num);
          14'h007: n_badv   = apply_write(m_badv, bus.csr_num);
          14'h00C: n_eentry = apply_write(m_eentry, bus.csr_num);
          14'h040: n_tid    = apply_write(m_tid, bus.csr_num);
          14'h041: n_tcfg   = apply_write(m_tcfg, bus.csr_num);
          14'h044: ticlr    = bus.csr_wvalue[0] && bus.csr_wmask[0];
          default: ;
        endcase
      end
      n_estat[9:2] = hw_int_in;
      n_estat[12]  = ipi_int_in;
      if (ticlr) n_estat[11] = 1'b0;
      if (tcfg_wr) begin
        if (n_tcfg[0]) n_tval = n_tcfg & ~32'd3;
      end else if (m_tcfg[0] && m_tval != 0) begin
        if (m_tval == 1) begin
          n_estat[11] = 1'b1;
          n_tval = m_tcfg[1] ? (m_tcfg & ~32'd3) : 32'd0;
        end else begin
          n_tval = m_tval - 1;
        end
      end
      m_crmd <= n_crmd; m_prmd <= n_prmd; m_ecfg <= n_ecfg; m_estat <= n_estat;
      m_era <= n_era; m_badv <= n_badv; m_eentry <= n_eentry; m_tid <= n_tid;
      m_tcfg <= n_tcfg; m_tval <= n_tval;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("cmp_rvalue", bus.csr_rvalue, model_read(bus.csr_num));
      checkOutput("cmp_ex_entry", bus.ex_entry, m_eentry);
      checkOutput("cmp_era_out", bus.era_out, m_era);
      checkOutput("cmp_has_int", {31'b0, bus.has_int}, {31'b0, model_has_int()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [13:0] num, input logic [31:0] mask,
                               input logic [31:0] val, input logic ex, input logic ertn,
                               input logic [5:0] ecode, input logic [8:0] esub,
                               input logic [31:0] pc, input logic [31:0] vaddr);
    bus.csr_we      = we;
    bus.csr_num     = num;
    bus.csr_wmask   = mask;
    bus.csr_wvalue  = val;
    bus.wb_ex       = ex;
    bus.ertn_flush  = ertn;
    bus.wb_ecode    = ecode;
    bus.wb_esubcode = esub;
    bus.wb_pc       = pc;
    bus.wb_vaddr    = vaddr;
    tick();
    bus.csr_we     = 1'b0;
    bus.wb_ex      = 1'b0;
    bus.ertn_flush = 1'b0;
  endtask

  task automatic writeCsr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    applyStimulus(1'b1, num, mask, val, 1'b0, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0);
  endtask

  task automatic raiseEx(input logic [5:0] ecode, input logic [8:0] esub,
                         input logic [31:0] pc, input logic [31:0] vaddr);
    applyStimulus(1'b0, 14'h0, 32'h0, 32'h0, 1'b1, 1'b0, ecode, esub, pc, vaddr);
  endtask

  task automatic checkCsr(input string name, input logic [13:0] num,
                          input logic [31:0] mask, input logic [31:0] req);
    bus.csr_num = num;
    #1;
    checkOutput(name, bus.csr_rvalue & mask, req);
  endtask

  initial begin
    resetn = 1'b1;
    hw_int_in = 8'h0;
    ipi_int_in = 1'b0;
    bus.csr_num = 14'h0; bus.csr_we = 1'b0; bus.csr_wmask = 32'h0; bus.csr_wvalue = 32'h0;
    bus.wb_ex = 1'b0; bus.ertn_flush = 1'b0; bus.wb_ecode = 6'h0; bus.wb_esubcode = 9'h0;
    bus.wb_pc = 32'h0; bus.wb_vaddr = 32'h0;
    #2 resetn = 1'b0;
    checkCsr("rst_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0000_0008);
    checkCsr("rst_tval", 14'h042, 32'hFFFF_FFFF, 32'h0);
    checkOutput("rst_has_int", {31'b0, bus.has_int}, 32'h0);
    checkOutput("rst_ex_entry", bus.ex_entry, 32'h0);
    checkOutput("rst_era_out", bus.era_out, 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Exception entry from PLV3 with interrupts on, ALE records vaddr.
    writeCsr(14'h000, 32'h7, 32'h7);
    checkCsr("crmd_plv3_ie", 14'h000, 32'hFFFF_FFFF, 32'h0000_000F);
    raiseEx(6'h09, 9'h0, 32'h1C00_0100, 32'h0000_0123);
    checkCsr("ex_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0000_0008);
    checkCsr("ex_prmd", 14'h001, 32'hFFFF_FFFF, 32'h0000_0007);
    checkCsr("ex_era", 14'h006, 32'hFFFF_FFFF, 32'h1C00_0100);
    checkCsr("ex_badv_ale", 14'h007, 32'hFFFF_FFFF, 32'h0000_0123);
    checkCsr("ex_ecode", 14'h005, 32'h7FFF_0000, 32'h0009_0000);
    checkOutput("ex_era_out", bus.era_out, 32'h1C00_0100);
    applyStimulus(1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b1, 6'h0, 9'h0, 32'h0, 32'h0);
    checkCsr("ertn_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0000_000F);

    // ADE records PC; other ecodes leave BADV alone.
    raiseEx(6'h08, 9'h1A5, 32'h1C00_0008, 32'hFFFF_0000);
    checkCsr("ade_badv", 14'h007, 32'hFFFF_FFFF, 32'h1C00_0008);
    checkCsr("ade_estat", 14'h005, 32'h7FFF_0000, 32'h6948_0000);
    raiseEx(6'h0B, 9'h0, 32'h1C00_0200, 32'hAAAA_0000);
    checkCsr("other_badv", 14'h007, 32'hFFFF_FFFF, 32'h1C00_0008);
    checkCsr("other_era", 14'h006, 32'hFFFF_FFFF, 32'h1C00_0200);
    checkCsr("other_ecode", 14'h005, 32'h003F_0000, 32'h000B_0000);

    // EENTRY low bits and ECFG reserved bits are not writable.
    writeCsr(14'h00C, 32'hFFFF_FFFF, 32'h1C00_803F);
    checkOutput("eentry_out", bus.ex_entry, 32'h1C00_8000);
    writeCsr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkCsr("ecfg_all", 14'h004, 32'hFFFF_FFFF, 32'h0000_1BFF);
    writeCsr(14'h004, 32'hFFFF_FFFF, 32'h0000_0800);
    writeCsr(14'h000, 32'h4, 32'h4);
    checkCsr("crmd_ie_only", 14'h000, 32'hFFFF_FFFF, 32'h0000_000C);

    // Periodic timer, InitVal=3.
    writeCsr(14'h041, 32'hFFFF_FFFF, 32'h0000_000F);
    checkCsr("tval_load", 14'h042, 32'hFFFF_FFFF, 32'd12);
    checkOutput("tmr_no_int", {31'b0, bus.has_int}, 32'h0);
    for (int k = 11; k >= 1; k--) begin
      tick();
      checkCsr("tval_count", 14'h042, 32'hFFFF_FFFF, 32'(k));
    end
    tick();
    checkCsr("tval_reload", 14'h042, 32'hFFFF_FFFF, 32'd12);
    checkOutput("tmr_has_int", {31'b0, bus.has_int}, 32'h1);
    checkCsr("tmr_is11", 14'h005, 32'h0000_0800, 32'h0000_0800);
    writeCsr(14'h044, 32'h1, 32'h1);
    checkCsr("ticlr_is11", 14'h005, 32'h0000_0800, 32'h0);
    checkOutput("ticlr_has_int", {31'b0, bus.has_int}, 32'h0);
    checkCsr("ticlr_read", 14'h044, 32'hFFFF_FFFF, 32'h0);
    writeCsr(14'h041, 32'h1, 32'h0);
    checkCsr("tval_freeze", 14'h042, 32'hFFFF_FFFF, 32'd11);
    checkCsr("tcfg_read", 14'h041, 32'hFFFF_FFFF, 32'h0000_000E);
    tick();
    checkCsr("tval_frozen", 14'h042, 32'hFFFF_FFFF, 32'd11);

    // One-shot timer, InitVal=1: fires once then parks at zero.
    writeCsr(14'h041, 32'hFFFF_FFFF, 32'h0000_0005);
    checkCsr("os_load", 14'h042, 32'hFFFF_FFFF, 32'd4);
    for (int k = 3; k >= 1; k--) begin
      tick();
      checkCsr("os_count", 14'h042, 32'hFFFF_FFFF, 32'(k));
    end
    tick();
    checkCsr("os_zero", 14'h042, 32'hFFFF_FFFF, 32'd0);
    checkCsr("os_is11", 14'h005, 32'h0000_0800, 32'h0000_0800);
    tick();
    checkCsr("os_hold", 14'h042, 32'hFFFF_FFFF, 32'd0);
    writeCsr(14'h044, 32'hFFFF_FFFF, 32'h1);

    // Priority: exception beats a same-cycle ERA write; ertn beats a CRMD write.
    applyStimulus(1'b1, 14'h006, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b0,
                  6'h00, 9'h0, 32'h1C00_0300, 32'h0);
    checkCsr("prio_era", 14'h006, 32'hFFFF_FFFF, 32'h1C00_0300);
    checkCsr("prio_prmd", 14'h001, 32'hFFFF_FFFF, 32'h0000_0004);
    checkCsr("prio_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0000_0008);
    applyStimulus(1'b1, 14'h000, 32'h1F, 32'h1F, 1'b0, 1'b1, 6'h0, 9'h0, 32'h0, 32'h0);
    checkCsr("ertn_prio", 14'h000, 32'hFFFF_FFFF, 32'h0000_000C);

    // External and inter-processor interrupts.
    writeCsr(14'h004, 32'hFFFF_FFFF, 32'h0000_0004);
    hw_int_in = 8'h01;
    tick();
    checkCsr("hw_is2", 14'h005, 32'h0000_03FC, 32'h0000_0004);
    checkOutput("hw_has_int", {31'b0, bus.has_int}, 32'h1);
    hw_int_in = 8'h00;
    tick();
    checkOutput("hw_gone", {31'b0, bus.has_int}, 32'h0);
    ipi_int_in = 1'b1;
    writeCsr(14'h004, 32'hFFFF_FFFF, 32'h0000_1000);
    checkCsr("ipi_is12", 14'h005, 32'h0000_1000, 32'h0000_1000);
    checkOutput("ipi_has_int", {31'b0, bus.has_int}, 32'h1);
    ipi_int_in = 1'b0;
    writeCsr(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkCsr("estat_sw", 14'h005, 32'hFFFF_FFFF, 32'h0000_0003);

    // Partial masks, TID and unmapped space.
    writeCsr(14'h006, 32'h0000_FFFF, 32'h1234_5678);
    checkOutput("era_masked", bus.era_out, 32'h1C00_5678);
    writeCsr(14'h040, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    checkCsr("tid_rw", 14'h040, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    writeCsr(14'h010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkCsr("unmapped", 14'h010, 32'hFFFF_FFFF, 32'h0);

    // Reset in the middle of a count clears everything at once.
    hw_int_in = 8'hFF;
    writeCsr(14'h041, 32'hFFFF_FFFF, 32'h0000_000F);
    tick();
    tick();
    resetn = 1'b0;
    checkCsr("mid_rst_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0000_0008);
    checkCsr("mid_rst_tval", 14'h042, 32'hFFFF_FFFF, 32'h0);
    checkCsr("mid_rst_estat", 14'h005, 32'hFFFF_FFFF, 32'h0);
    checkCsr("mid_rst_tid", 14'h040, 32'hFFFF_FFFF, 32'h0);
    checkOutput("mid_rst_era", bus.era_out, 32'h0);
    checkOutput("mid_rst_entry", bus.ex_entry, 32'h0);
    checkOutput("mid_rst_int", {31'b0, bus.has_int}, 32'h0);
    tick();
    tick();
    checkCsr("held_rst_estat", 14'h005, 32'hFFFF_FFFF, 32'h0);
    hw_int_in = 8'h00;
    resetn = 1'b1;
    tick();
    checkCsr("post_rst_crmd", 14'h000, 32'hFFFF_FFFF, 32'h0000_0008);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/csr_exc_unit.md
Name: csr_exc_unit

Overview:
- CSR-side receiver of the WB-stage exception/ertn interface (wb_ex, ertn_flush, wb_ecode, wb_esubcode, wb_pc, wb_vaddr).
- Holds the LA32 exception-related CSRs and runs the architectural timer.
- Provides the CSR read/write port used by csrrd/csrwr/csrxchg.
- Returns the redirect targets (EENTRY / ERA) and the pending-interrupt flag to the front end and ID.

Parameters:
- TIMER_W, 32, width of TVAL; InitVal occupies TCFG[TIMER_W-1:2].
- TID_RST, 32'h0, reset value of TID.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- csr_num  in  14  CSR address from WB.
- csr_we  in  1  CSR write strobe (already qualified by ws_valid).
- csr_wmask  in  32  per-bit write mask.
- csr_wvalue  in  32  write data.
- csr_rvalue  out  32  combinational read data for csr_num.
- wb_ex  in  1  exception commit from WB.
- ertn_flush  in  1  ertn commit from WB.
- wb_ecode  in  6  exception code.
- wb_esubcode  in  9  exception subcode.
- wb_pc  in  32  PC of the committing instruction.
- wb_vaddr  in  32  faulting data address.
- hw_int_in  in  8  external interrupt lines.
- ipi_int_in  in  1  inter-processor interrupt.
- ex_entry  out  32  EENTRY value; target on wb_ex.
- era_out  out  32  ERA value; target on ertn_flush.
- has_int  out  1  interrupt pending and enabled; ID tags the next instruction with INT.

Behaviour:
Reset (async, resetn=0):
- CRMD = 32'h8 (DA=1, PG=0, PLV=0, IE=0).
- PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, TCFG, TVAL = 0.
- TID = TID_RST.
- Outputs follow the registers: ex_entry=0, era_out=0, has_int=0, csr_rvalue reflects csr_num.

CSR map and writable bits (new = old&~mask | wvalue&mask, applied only to the writable bits):
- CRMD 0x0: [4:0] writable.
- PRMD 0x1: [2:0] writable.
- ECFG 0x4: LIE [12:11],[9:0] writable.
- ESTAT 0x5: only IS[1:0] writable.
- ERA 0x6: all bits writable.
- BADV 0x7: all bits writable.
- EENTRY 0xC: [31:6] writable.
- TID 0x40: all bits writable.
- TCFG 0x41: En[0], Periodic[1], InitVal[TIMER_W-1:2] writable.
- TVAL 0x42: read-only.
- TICLR 0x44: reads 0; a write with wvalue&mask bit0=1 clears IS[11].
- Unmapped addresses read 0; writes to them are ignored.
- All unwritable bits read 0, except ESTAT.Ecode[21:16] and EsubCode[30:22], which are hardware-set.

Commit events (all registered, effective next cycle). Priority: wb_ex > ertn_flush > csr_we; the lower-priority event is dropped in the same cycle.
- wb_ex:
  - PRMD.PPLV <= CRMD.PLV; PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0; CRMD.IE <= 0.
  - ESTAT.Ecode <= wb_ecode; ESTAT.EsubCode <= wb_esubcode.
  - ERA <= wb_pc.
  - BADV: ecode 0x08 (ADE) -> BADV <= wb_pc; ecode 0x09 (ALE) -> BADV <= wb_vaddr; otherwise BADV unchanged.
- ertn_flush: CRMD.PLV <= PRMD.PPLV; CRMD.IE <= PRMD.PIE.

Interrupt sampling:
- ESTAT.IS[9:2] <= hw_int_in every cycle.
- ESTAT.IS[12] <= ipi_int_in every cycle.

Timer (per cycle):
- A TCFG write with new En=1 loads TVAL <= {InitVal,2'b00}. A TCFG write with En=0 freezes TVAL.
- Otherwise, with En=1 and TVAL!=0: TVAL <= TVAL-1.
- When TVAL==1 with En=1:
  - set IS[11];
  - Periodic=1: TVAL <= {InitVal,2'b00};
  - Periodic=0: TVAL <= 0 and stays 0 (no further interrupts until reloaded).
- TVAL==0 with En=1 and no write: hold.
- Timer set and TICLR clear in the same cycle: set wins.

Outputs:
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]). Combinational from registers.
- ex_entry = EENTRY; era_out = ERA. csr_rvalue is combinational from the registers, so there is no write-to-read bypass: a write is visible on csr_rvalue one cycle later.
- Reset asserted mid-count clears the timer and any pending IS immediately.

Test Plan:
- Reset, then read 0x0 -> 32'h8; TVAL=0; has_int=0; ex_entry=0.
- Set CRMD PLV=3, IE=1; wb_ex, ecode 0x09, wb_pc=1C000100, wb_vaddr=00000123 -> next cycle: CRMD[2:0]=0, PRMD[2:0]=3'b111, ERA=1C000100, BADV=00000123, ESTAT[21:16]=09. A following ertn_flush -> CRMD[2:0]=3'b111.
- wb_ex, ecode 0x08, wb_pc=1C000008 -> BADV=1C000008. wb_ex with ecode 0x0B -> BADV unchanged.
- TCFG write 0x0000000F (InitVal=3, Periodic, En) -> TVAL=12,11,...,1. Cycle after TVAL=1: IS[11]=1, TVAL=12. TICLR write 1 -> IS[11]=0. With LIE[11]=1 and IE=1, has_int=1 while IS[11]=1.
- Same cycle: wb_ex plus csr_we to ERA with value DEADBEEF -> ERA=wb_pc (the write is dropped). Masked write to CRMD with mask 32'h4, value 32'h4 -> only IE changes.
- hw_int_in=8'h01 with LIE[2]=1, IE=1 -> IS[2]=1 next cycle, has_int=1. Pulse resetn low mid-count -> all registers at reset values immediately.
